// File: rtl/proc_control_if.sv
// Signal bundle between the processor control unit and its datapath / step counter.
// The control unit sits on the slave modport; the datapath side (or a bench) uses master.
interface proc_control_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              run;
  logic [DATA_W-1:0] din;
  logic [2:0]        tstep;
  logic              gnz;
  logic              ir_in;
  logic [7:0]        r_in;
  logic [7:0]        r_out;
  logic              a_in;
  logic              g_in;
  logic              g_out;
  logic              din_out;
  logic              add_sub;
  logic              done;
  logic              clear;
  logic              illegal;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output run, din, tstep, gnz,
    input  ir_in, r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done, clear,
           illegal, instr_count
  );

  modport slave (
    input  run, din, tstep, gnz,
    output ir_in, r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done, clear,
           illegal, instr_count
  );
endinterface

// File: rtl/proc_control.sv
// Multi-cycle processor control unit: holds the instruction register and decodes
// opcode plus step into datapath strobes; also keeps a sticky illegal flag and retire count.
module proc_control #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  proc_control_if.slave bus
);

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MVNZ = 3'b100
  } opcode_e;

  logic [8:0]       ir_q, ir_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       ir_in_s, a_in_s, g_in_s, g_out_s, din_out_s, add_sub_s, done_s, clear_s;
  logic [7:0] r_in_s, r_out_s;
  logic       bad_step_s, illegal_op_s;
  opcode_e    op_s;
  logic [2:0] rx_s, ry_s;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'b0000_0001 << idx;
  endfunction

  assign op_s = opcode_e'(ir_q[8:6]);
  assign rx_s = ir_q[5:3];
  assign ry_s = ir_q[2:0];

  // Strobe decode from reset, step, registered instruction, run and gnz
  always_comb begin
    ir_in_s      = 1'b0;
    r_in_s       = 8'h00;
    r_out_s      = 8'h00;
    a_in_s       = 1'b0;
    g_in_s       = 1'b0;
    g_out_s      = 1'b0;
    din_out_s    = 1'b0;
    add_sub_s    = 1'b0;
    done_s       = 1'b0;
    bad_step_s   = 1'b0;
    illegal_op_s = 1'b0;
    if (reset) begin
      ir_in_s = 1'b0;
    end else if (bus.tstep == 3'd0) begin
      ir_in_s = bus.run;
    end else begin
      case (op_s)
        OP_MV: begin
          if (bus.tstep == 3'd1) begin
            r_out_s = onehot8(ry_s);
            r_in_s  = onehot8(rx_s);
            done_s  = 1'b1;
          end else begin
            bad_step_s = 1'b1;
          end
        end
        OP_MVI: begin
          if (bus.tstep == 3'd1) begin
            din_out_s = 1'b1;
            r_in_s    = onehot8(rx_s);
            done_s    = 1'b1;
          end else begin
            bad_step_s = 1'b1;
          end
        end
        OP_ADD, OP_SUB: begin
          case (bus.tstep)
            3'd1: begin
              r_out_s = onehot8(rx_s);
              a_in_s  = 1'b1;
            end
            3'd2: begin
              r_out_s   = onehot8(ry_s);
              g_in_s    = 1'b1;
              add_sub_s = (op_s == OP_SUB);
            end
            3'd3: begin
              g_out_s = 1'b1;
              r_in_s  = onehot8(rx_s);
              done_s  = 1'b1;
            end
            default: bad_step_s = 1'b1;
          endcase
        end
        OP_MVNZ: begin
          if (bus.tstep == 3'd1) begin
            done_s = 1'b1;
            if (bus.gnz) begin
              r_out_s = onehot8(ry_s);
              r_in_s  = onehot8(rx_s);
            end else begin
              r_out_s = 8'h00;
            end
          end else begin
            bad_step_s = 1'b1;
          end
        end
        default: begin
          // Undefined opcodes retire in one step without touching registers
          if (bus.tstep == 3'd1) begin
            done_s       = 1'b1;
            illegal_op_s = 1'b1;
          end else begin
            bad_step_s = 1'b1;
          end
        end
      endcase
    end
    clear_s = reset | done_s | ((bus.tstep == 3'd0) & ~bus.run) | bad_step_s;
  end

  // Next-state for instruction register, sticky illegal flag and retire counter
  always_comb begin
    if (ir_in_s) begin
      ir_d = bus.din[DATA_W-1 -: 9];
    end else begin
      ir_d = ir_q;
    end
    illegal_d = illegal_q | bad_step_s | illegal_op_s;
    if (done_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q      <= 9'h000;
      illegal_q <= 1'b0;
      count_q   <= {CNT_W{1'b0}};
    end else begin
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign bus.ir_in       = ir_in_s;
  assign bus.r_in        = r_in_s;
  assign bus.r_out       = r_out_s;
  assign bus.a_in        = a_in_s;
  assign bus.g_in        = g_in_s;
  assign bus.g_out       = g_out_s;
  assign bus.din_out     = din_out_s;
  assign bus.add_sub     = add_sub_s;
  assign bus.done        = done_s;
  assign bus.clear       = clear_s;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_proc_control.sv
// Directed, table-driven bench for proc_control; the step counter is played by the bench.
module tb_proc_control;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;
  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  logic clk;
  logic reset;

  proc_control_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  proc_control #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        run;
    logic [15:0] din;
    logic [2:0]  tstep;
    logic        gnz;
    logic [23:0] exp_st;
    logic        exp_ill;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   tests;
  int   fails;

  // Strobe vector: {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done, clear}
  function automatic logic [23:0] st(input logic ir_in, input logic [7:0] r_in,
                                     input logic [7:0] r_out, input logic a_in,
                                     input logic g_in, input logic g_out,
                                     input logic din_out, input logic add_sub,
                                     input logic done, input logic clear);
    return {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done, clear};
  endfunction

  function automatic logic [15:0] ins(input logic [2:0] op, input logic [2:0] x,
                                      input logic [2:0] y);
    return {op, x, y, 7'b000_0000};
  endfunction

  function automatic logic [23:0] got_st();
    return {bus.ir_in, bus.r_in, bus.r_out, bus.a_in, bus.g_in, bus.g_out,
            bus.din_out, bus.add_sub, bus.done, bus.clear};
  endfunction

  task automatic add(input string name, input logic rst, input logic run,
                     input logic [15:0] din, input logic [2:0] tstep, input logic gnz,
                     input logic [23:0] exp_st, input logic exp_ill, input logic [15:0] exp_cnt);
    vec_t v;
    v.name = name; v.rst = rst; v.run = run; v.din = din; v.tstep = tstep; v.gnz = gnz;
    v.exp_st = exp_st; v.exp_ill = exp_ill; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  logic [23:0] s_none, s_clr, s_fetch, s_add1, s_add2, s_sub2, s_add3;
  logic        clr_seen;
  int          nbus;

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.run = 1'b0;
    bus.din = 16'h0000;
    bus.tstep = 3'd0;
    bus.gnz = 1'b0;

    s_none  = st(L0, 8'h00, 8'h00, L0, L0, L0, L0, L0, L0, L0);
    s_clr   = st(L0, 8'h00, 8'h00, L0, L0, L0, L0, L0, L0, L1);
    s_fetch = st(L1, 8'h00, 8'h00, L0, L0, L0, L0, L0, L0, L0);
    s_add1  = st(L0, 8'h00, 8'h02, L1, L0, L0, L0, L0, L0, L0);
    s_add2  = st(L0, 8'h00, 8'h04, L0, L1, L0, L0, L0, L0, L0);
    s_sub2  = st(L0, 8'h00, 8'h04, L0, L1, L0, L0, L1, L0, L0);
    s_add3  = st(L0, 8'h02, 8'h00, L0, L0, L1, L0, L0, L1, L1);

    add("rst_a",     L1, L0, 16'h0000,         3'd0, L0, s_clr, L0, 16'd0);
    add("rst_b",     L1, L0, 16'h0000,         3'd0, L0, s_clr, L0, 16'd0);
    add("idle_a",    L0, L0, 16'h0000,         3'd0, L0, s_clr, L0, 16'd0);
    add("idle_b",    L0, L0, 16'hFFFF,         3'd0, L0, s_clr, L0, 16'd0);
    add("idle_c",    L0, L0, 16'h0000,         3'd0, L0, s_clr, L0, 16'd0);
    add("mvi_t0",    L0, L1, ins(3'd1, 3'd3, 3'd0), 3'd0, L0, s_fetch, L0, 16'd0);
    add("mvi_t1",    L0, L0, 16'hBEEF,         3'd1, L0,
        st(L0, 8'h08, 8'h00, L0, L0, L0, L1, L0, L1, L1), L0, 16'd0);
    add("add_t0",    L0, L1, ins(3'd2, 3'd1, 3'd2), 3'd0, L0, s_fetch, L0, 16'd1);
    add("add_t1",    L0, L0, 16'h0000,         3'd1, L0, s_add1, L0, 16'd1);
    add("add_t2",    L0, L0, 16'h0000,         3'd2, L0, s_add2, L0, 16'd1);
    add("add_t3",    L0, L0, 16'h0000,         3'd3, L0, s_add3, L0, 16'd1);
    add("sub_t0",    L0, L1, ins(3'd3, 3'd1, 3'd2), 3'd0, L0, s_fetch, L0, 16'd2);
    add("sub_t1",    L0, L1, 16'h0000,         3'd1, L0, s_add1, L0, 16'd2);
    add("sub_t2",    L0, L1, 16'h0000,         3'd2, L0, s_sub2, L0, 16'd2);
    add("sub_t3",    L0, L1, 16'h0000,         3'd3, L0, s_add3, L0, 16'd2);
    add("mvnz0_t0",  L0, L1, ins(3'd4, 3'd0, 3'd5), 3'd0, L0, s_fetch, L0, 16'd3);
    add("mvnz0_t1",  L0, L0, 16'h0000,         3'd1, L0,
        st(L0, 8'h00, 8'h00, L0, L0, L0, L0, L0, L1, L1), L0, 16'd3);
    add("mvnz1_t0",  L0, L1, ins(3'd4, 3'd0, 3'd5), 3'd0, L1, s_fetch, L0, 16'd4);
    add("mvnz1_t1",  L0, L0, 16'h0000,         3'd1, L1,
        st(L0, 8'h01, 8'h20, L0, L0, L0, L0, L0, L1, L1), L0, 16'd4);
    add("op7_t0",    L0, L1, ins(3'd7, 3'd2, 3'd3), 3'd0, L0, s_fetch, L0, 16'd5);
    add("op7_t1",    L0, L0, 16'h0000,         3'd1, L0,
        st(L0, 8'h00, 8'h00, L0, L0, L0, L0, L0, L1, L1), L0, 16'd5);
    add("mv_t0",     L0, L1, ins(3'd0, 3'd4, 3'd6), 3'd0, L0, s_fetch, L1, 16'd6);
    add("mv_t1",     L0, L0, 16'h0000,         3'd1, L0,
        st(L0, 8'h10, 8'h40, L0, L0, L0, L0, L0, L1, L1), L1, 16'd6);
    add("add2_t0",   L0, L1, ins(3'd2, 3'd1, 3'd2), 3'd0, L0, s_fetch, L1, 16'd7);
    add("add2_t1",   L0, L0, 16'h0000,         3'd1, L0, s_add1, L1, 16'd7);
    add("rst_mid",   L1, L0, 16'h0000,         3'd2, L0, s_clr, L0, 16'd0);
    add("ir_zero",   L0, L0, 16'h0000,         3'd1, L0,
        st(L0, 8'h01, 8'h01, L0, L0, L0, L0, L0, L1, L1), L0, 16'd0);
    add("idle_d",    L0, L0, 16'h0000,         3'd0, L0, s_clr, L0, 16'd1);
    add("mvb_t0",    L0, L1, ins(3'd0, 3'd1, 3'd1), 3'd0, L0, s_fetch, L0, 16'd1);
    add("mvb_t5",    L0, L0, 16'h0000,         3'd5, L0, s_clr, L0, 16'd1);
    add("idle_e",    L0, L0, 16'h0000,         3'd0, L0, s_clr, L1, 16'd1);
    add("mvc_t0",    L0, L1, ins(3'd0, 3'd2, 3'd1), 3'd0, L0, s_fetch, L1, 16'd1);
    add("mvc_t2",    L0, L0, 16'h0000,         3'd2, L0, s_clr, L1, 16'd1);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      reset     = vecs[k].rst;
      bus.run   = vecs[k].run;
      bus.din   = vecs[k].din;
      bus.tstep = vecs[k].tstep;
      bus.gnz   = vecs[k].gnz;
      #1;
      chk({vecs[k].name, "_strobes"}, k, {8'h00, got_st()}, {8'h00, vecs[k].exp_st});
      chk({vecs[k].name, "_illegal"}, k, {31'd0, bus.illegal}, {31'd0, vecs[k].exp_ill});
      chk({vecs[k].name, "_count"}, k, {16'd0, bus.instr_count}, {16'd0, vecs[k].exp_cnt});
      nbus = $countones(bus.r_out) + int'(bus.g_out) + int'(bus.din_out);
      chk({vecs[k].name, "_bus_excl"}, k, {31'd0, (nbus <= 1)}, 32'd1);
    end

    // Back-to-back mvi with run held high; the bench step counter obeys clear
    bus.run = 1'b1;
    bus.din = ins(3'd1, 3'd5, 3'd0);
    bus.gnz = 1'b0;
    clr_seen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.tstep = clr_seen ? 3'd0 : bus.tstep + 3'd1;
      #1;
      if (i % 2 == 0) begin
        chk("b2b_fetch", i, {8'h00, got_st()}, {8'h00, s_fetch});
      end else begin
        chk("b2b_exec", i, {8'h00, got_st()},
            {8'h00, st(L0, 8'h20, 8'h00, L0, L0, L0, L1, L0, L1, L1)});
      end
      chk("b2b_count", i, {16'd0, bus.instr_count}, 32'd1 + 32'(i / 2));
      clr_seen = bus.clear;
    end
    @(negedge clk);
    bus.run   = 1'b0;
    bus.tstep = 3'd0;
    #1;
    chk("b2b_final_count", 0, {16'd0, bus.instr_count}, 32'd4);
    chk("b2b_illegal_sticky", 0, {31'd0, bus.illegal}, 32'd1);
    chk("b2b_idle_clear", 0, {8'h00, got_st()}, {8'h00, s_clr});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
